// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA raster engine.
// Holds the per-axis timing tuple, the 640x480@60 default timing, the
// colour-bar table and the record carried through the fetch delay line.
// Optional feature macro: VGA_TEST_PATTERN_EN (adds the delayed column
// to the delay-line record so the colour bars can be drawn).
package vga_pkg;

    // One axis worth of timing, in pixels (horizontal) or lines (vertical)
    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    // 640x480@60 with a 25 MHz pixel clock derived from 100 MHz
    localparam timing_t VGA_640_H     = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam timing_t VGA_480_V     = '{active: 480, fp: 10, sync: 2,  bp: 33};
    localparam int      VGA_CLK_DIV   = 4;
    localparam int      VGA_COLOR_W   = 4;
    localparam int      VGA_FETCH_LAT = 2;

    // Counters are 16 bits wide, so a full line or frame must fit in them
    localparam int COUNT_W   = 16;
    localparam int COUNT_MAX = 65535;

    // Colour-bar flags {r,g,b}, listed left to right across the screen
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        logic [2:0] flags;
        case (idx)
            3'd0:    flags = BAR_WHITE;
            3'd1:    flags = BAR_YELLOW;
            3'd2:    flags = BAR_CYAN;
            3'd3:    flags = BAR_GREEN;
            3'd4:    flags = BAR_MAGENTA;
            3'd5:    flags = BAR_RED;
            3'd6:    flags = BAR_BLUE;
            default: flags = BAR_BLACK;
        endcase
        return flags;
    endfunction

    function automatic int timing_total(input timing_t t);
        return t.sync + t.bp + t.active + t.fp;
    endfunction

    // What the display side needs to know about a requested pixel.
    // The sync bits are stored unpolarised: 0 always means "deasserted",
    // so a cleared delay line naturally produces idle syncs.
    typedef struct packed {
`ifdef VGA_TEST_PATTERN_EN
        logic [COUNT_W-1:0] x;
`endif
        logic hs;
        logic vs;
        logic act;
    } disp_info_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Counts 0..TOTAL-1 while enabled and reports the terminal count plus
// which region (sync / active) the current position falls in.
// Region order along the axis: sync, back porch, active, front porch.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int FP     = 16
)(
    input  logic               clk_in,
    input  logic               rst,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               in_sync,
    output logic               in_active
);

    localparam timing_t            AXIS     = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
    localparam int                 TOTAL    = timing_total(AXIS);
    localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_END = COUNT_W'(SYNC);
    localparam logic [COUNT_W-1:0] ACT_LO   = COUNT_W'(SYNC + BP);
    localparam logic [COUNT_W-1:0] ACT_HI   = COUNT_W'(SYNC + BP + ACTIVE);

    generate
        if (TOTAL > COUNT_MAX || TOTAL < 1) begin : g_bad_total
            $error("vga_axis_counter: axis total %0d does not fit a 16-bit counter", TOTAL);
        end
    endgenerate

    // Terminal count only matters on an enabled step, so it doubles as the
    // enable for whatever axis sits above this one
    assign wrap      = en && (count == LAST);
    assign in_sync   = (count < SYNC_END);
    assign in_active = (count >= ACT_LO) && (count < ACT_HI);

    // Position register: steps on enable, returns to zero after the last slot
    always_ff @(posedge clk_in) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster/timing engine.
// A clock-enable divider produces the pixel tick; two axis counters walk
// the raster and issue pixel requests FETCH_LAT ticks ahead of display so
// the frame-buffer read path can return rgb_in in step with the delayed
// syncs. Optional feature macro: VGA_TEST_PATTERN_EN adds pattern_en,
// which swaps rgb_in for eight vertical colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_ACTIVE  = VGA_640_H.active,
    parameter int H_FP      = VGA_640_H.fp,
    parameter int H_SYNC    = VGA_640_H.sync,
    parameter int H_BP      = VGA_640_H.bp,
    parameter int V_ACTIVE  = VGA_480_V.active,
    parameter int V_FP      = VGA_480_V.fp,
    parameter int V_SYNC    = VGA_480_V.sync,
    parameter int V_BP      = VGA_480_V.bp,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int COLOR_W   = VGA_COLOR_W,
    parameter int FETCH_LAT = VGA_FETCH_LAT
)(
    input  logic                 clk_in,
    input  logic                 rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 pattern_en,
`endif
    output logic                 req_valid,
    output logic [15:0]          req_x,
    output logic [15:0]          req_y,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic                 pix_tick,
    output logic                 frame_start,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 active,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic               HS_ON    = (HS_POL != 0);
    localparam logic               VS_ON    = (VS_POL != 0);
    localparam logic [COUNT_W-1:0] X_OFF    = COUNT_W'(H_SYNC + H_BP);
    localparam logic [COUNT_W-1:0] Y_OFF    = COUNT_W'(V_SYNC + V_BP);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1 (got %0d)", CLK_DIV);
        end
        if (FETCH_LAT < 0 || FETCH_LAT > 15) begin : g_bad_lat
            $error("vga_timing_gen: FETCH_LAT must be 0..15 (got %0d)", FETCH_LAT);
        end
    endgenerate

    logic [DIV_W-1:0]   div;
    logic [COUNT_W-1:0] h_cnt;
    logic [COUNT_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_in_sync;
    logic               v_in_sync;
    logic               h_in_active;
    logic               v_in_active;
    logic               at_origin;
    disp_info_t         cur_info;
    disp_info_t         tap;
    logic [3*COLOR_W-1:0] pix_rgb;

    // Pixel-rate clock enable: pix_tick is registered, so it is high for
    // exactly one clk_in in every CLK_DIV and is clean straight out of reset
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= (div == DIV_LAST);
            div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_axis (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (pix_tick),
        .count     (h_cnt),
        .wrap      (h_wrap),
        .in_sync   (h_in_sync),
        .in_active (h_in_active)
    );

    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_axis (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (h_wrap),
        .count     (v_cnt),
        .wrap      (v_wrap),
        .in_sync   (v_in_sync),
        .in_active (v_in_active)
    );

    // Request side follows the counters directly, so a request is held for
    // the whole pixel period and the tick cycle sees it
    assign req_valid = h_in_active && v_in_active;
    assign req_x     = req_valid ? (h_cnt - X_OFF) : '0;
    assign req_y     = req_valid ? (v_cnt - Y_OFF) : '0;

    // Tracks whether the counters sit at (0,0): set by the tick that ends a
    // frame and by reset, cleared by any other tick
    always_ff @(posedge clk_in) begin
        if (rst) begin
            at_origin <= 1'b1;
        end else if (pix_tick) begin
            at_origin <= v_wrap;
        end
    end

    assign frame_start = pix_tick && at_origin;

    assign cur_info.hs  = h_in_sync;
    assign cur_info.vs  = v_in_sync;
    assign cur_info.act = req_valid;
`ifdef VGA_TEST_PATTERN_EN
    assign cur_info.x   = req_x;
`endif

    // Tick-enabled delay line: the entry a request wrote reaches the tap on
    // the FETCH_LAT-th tick after it, the same tick rgb_in becomes valid
    generate
        if (FETCH_LAT == 0) begin : g_bypass
            assign tap = cur_info;
        end else begin : g_delay
            disp_info_t dly [FETCH_LAT];

            // Shift one slot per pixel tick; reset clears every slot to idle
            always_ff @(posedge clk_in) begin
                if (rst) begin
                    for (int i = 0; i < FETCH_LAT; i++) begin
                        dly[i] <= '0;
                    end
                end else if (pix_tick) begin
                    dly[0] <= cur_info;
                    for (int i = 1; i < FETCH_LAT; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign tap = dly[FETCH_LAT-1];
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    localparam int                 BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [COUNT_W-1:0] BAR_W16 = COUNT_W'(BAR_W);
    logic [COUNT_W-1:0] bar_q;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_rgb;

    // Bar number from the delayed column; a ragged last bar joins the black one
    assign bar_q   = tap.x / BAR_W16;
    assign bar_idx = (bar_q > COUNT_W'(7)) ? 3'd7 : bar_q[2:0];
    assign bar_rgb = bar_flags(bar_idx);
`endif

    // Pixel source: fetched data, or the colour bars when the pattern is on
    always_comb begin
        pix_rgb = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_en) begin
            pix_rgb = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
        end
`endif
    end

    // Display registers: load on the tick, hold between ticks, and blank
    // the colour outside the visible window
    always_ff @(posedge clk_in) begin
        if (rst) begin
            h_sync <= ~HS_ON;
            v_sync <= ~VS_ON;
            active <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (pix_tick) begin
            h_sync <= tap.hs ? HS_ON : ~HS_ON;
            v_sync <= tap.vs ? VS_ON : ~VS_ON;
            active <= tap.act;
            red    <= tap.act ? pix_rgb[3*COLOR_W-1:2*COLOR_W] : '0;
            green  <= tap.act ? pix_rgb[2*COLOR_W-1:COLOR_W]   : '0;
            blue   <= tap.act ? pix_rgb[COLOR_W-1:0]           : '0;
        end
    end

endmodule
